// File: rtl/mux4to1_4bit_and_array_pkg.sv
// Shared constants and helpers for the 4:1 AND-OR select array.
// One-hot select encodings and the popcount-based one-hot check live here.
package mux4to1_4bit_and_array_pkg;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned NSEL  = 4;

    localparam logic [NSEL-1:0] SEL_I0 = 4'b0001;
    localparam logic [NSEL-1:0] SEL_I1 = 4'b0010;
    localparam logic [NSEL-1:0] SEL_I2 = 4'b0100;
    localparam logic [NSEL-1:0] SEL_I3 = 4'b1000;

    function automatic logic [2:0] sel_popcount(input logic [NSEL-1:0] code);
        logic [2:0] cnt;
        cnt = '0;
        for (int unsigned k = 0; k < NSEL; k++) begin
            cnt = cnt + {2'b00, code[k]};
        end
        return cnt;
    endfunction

    function automatic logic is_one_hot(input logic [NSEL-1:0] code);
        return sel_popcount(code) == 3'd1;
    endfunction

endpackage

// File: rtl/mux4to1_4bit_and_array_if.sv
// Data/select bus between the digit sources and the select array.
// Signal names match the original module ports.
interface mux4to1_4bit_and_array_if
    import mux4to1_4bit_and_array_pkg::*;
#(
    parameter int unsigned W = WIDTH
);
    logic [NSEL-1:0] code;
    logic [W-1:0]    I0;
    logic [W-1:0]    I1;
    logic [W-1:0]    I2;
    logic [W-1:0]    I3;
    logic [W-1:0]    O;
    logic            err;

    modport master (
        output code, I0, I1, I2, I3,
        input  O, err
    );

    modport slave (
        input  code, I0, I1, I2, I3,
        output O, err
    );
endinterface

// File: rtl/mux4to1_4bit_and_array_and_or_lane.sv
// One bit-slice of the select array: each data bit gated by its select bit, results ORed.
// Multiple select bits simply OR their data; there is no priority.
module and_or_lane
    import mux4to1_4bit_and_array_pkg::*;
(
    input  logic [NSEL-1:0] d_i,
    input  logic [NSEL-1:0] sel_i,
    output logic            y_o
);
    logic [NSEL-1:0] gated;

    always_comb begin
        gated = '0;
        for (int unsigned k = 0; k < NSEL; k++) begin
            gated[k] = d_i[k] & sel_i[k];
        end
        y_o = |gated;
    end
endmodule

// File: rtl/mux4to1_4bit_and_array.sv
// Registered 4:1 AND-OR mux with one-hot select and select-error flag.
// Feeds the scoreboard digit decoder a glitch-free nibble every cycle.
module mux4to1_4bit_and_array
    import mux4to1_4bit_and_array_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    mux4to1_4bit_and_array_if.slave        bus
);
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] o_d, o_q;
    logic             err_d, err_q;

    for (genvar b = 0; b < WIDTH; b++) begin : g_lane
        and_or_lane u_lane (
            .d_i   ({bus.I3[b], bus.I2[b], bus.I1[b], bus.I0[b]}),
            .sel_i (bus.code),
            .y_o   (sel[b])
        );
    end

    always_comb begin
        o_d   = sel;
        err_d = ~is_one_hot(bus.code);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q   <= '0;
            err_q <= 1'b0;
        end else begin
            o_q   <= o_d;
            err_q <= err_d;
        end
    end

    assign bus.O   = o_q;
    assign bus.err = err_q;

    // A one-hot select must pass its input through untouched.
    property p_onehot_passthru;
        @(posedge clk) disable iff (rst)
            (bus.code == SEL_I2) |=> (bus.O == $past(bus.I2));
    endproperty
    a_onehot_passthru: assert property (p_onehot_passthru);

endmodule

// File: tb/tb_mux4to1_4bit_and_array.sv
module tb_mux4to1_4bit_and_array;
    import mux4to1_4bit_and_array_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mux4to1_4bit_and_array_if #(.W(WIDTH)) bus_if ();

    mux4to1_4bit_and_array dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] code;
        logic [3:0] i0, i1, i2, i3;
        logic [3:0] exp_o;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic [3:0] e);
        bus_if.code = c;
        bus_if.I0 = a;
        bus_if.I1 = b;
        bus_if.I2 = d;
        bus_if.I3 = e;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back('{"walk0", SEL_I0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 1'b0});
        vecs.push_back('{"walk1", SEL_I1, 4'h0, 4'h1, 4'h2, 4'h3, 4'h1, 1'b0});
        vecs.push_back('{"walk2", SEL_I2, 4'h0, 4'h1, 4'h2, 4'h3, 4'h2, 1'b0});
        vecs.push_back('{"walk3", SEL_I3, 4'h0, 4'h1, 4'h2, 4'h3, 4'h3, 1'b0});
        vecs.push_back('{"zero",  4'b0000, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 1'b1});
        vecs.push_back('{"m0110", 4'b0110, 4'h0, 4'h5, 4'hA, 4'h3, 4'hF, 1'b1});
        vecs.push_back('{"m1111", 4'b1111, 4'h0, 4'h1, 4'h2, 4'h3, 4'h3, 1'b1});
        vecs.push_back('{"m0101", 4'b0101, 4'h0, 4'h1, 4'h2, 4'h3, 4'h2, 1'b1});
        vecs.push_back('{"m0011", 4'b0011, 4'h8, 4'h1, 4'h2, 4'h3, 4'h9, 1'b1});
        vecs.push_back('{"i3hold",SEL_I3,  4'hF, 4'hF, 4'hF, 4'h6, 4'h6, 1'b0});
        vecs.push_back('{"i0only",SEL_I0,  4'h7, 4'h8, 4'h8, 4'h8, 4'h7, 1'b0});

        // Reset held across edges with a live select
        rst = 1'b1;
        drive(SEL_I1, 4'h0, 4'h1, 4'h2, 4'h3);
        repeat (3) @(negedge clk);
        chk("rst_o", bus_if.O, 4'h0);
        chk("rst_err", {3'b000, bus_if.err}, 4'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_o", bus_if.O, 4'h1);
        chk("rel_err", {3'b000, bus_if.err}, 4'h0);

        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n].code, vecs[n].i0, vecs[n].i1, vecs[n].i2, vecs[n].i3);
            @(negedge clk);
            chk({vecs[n].name, "_o"}, bus_if.O, vecs[n].exp_o);
            chk({vecs[n].name, "_err"}, {3'b000, bus_if.err}, {3'b000, vecs[n].exp_err});
        end

        // Held select, data changes
        drive(SEL_I3, 4'h0, 4'h1, 4'h2, 4'h3);
        @(negedge clk);
        chk("hold_a", bus_if.O, 4'h3);
        bus_if.I3 = 4'hC;
        @(negedge clk);
        chk("hold_c", bus_if.O, 4'hC);
        bus_if.I0 = 4'h5; bus_if.I1 = 4'hA; bus_if.I2 = 4'h9;
        @(negedge clk);
        chk("hold_unsel", bus_if.O, 4'hC);

        // Async reset between edges, O non-zero
        drive(SEL_I3, 4'h0, 4'h1, 4'h2, 4'h3);
        @(negedge clk);
        chk("pre_async_o", bus_if.O, 4'h3);
        #1 rst = 1'b1;
        #1 chk("async_o", bus_if.O, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("async_rel_o", bus_if.O, 4'h3);

        // Async reset clears err
        bus_if.code = 4'b0000;
        @(negedge clk);
        chk("pre_async_err", {3'b000, bus_if.err}, 4'h1);
        #1 rst = 1'b1;
        #1 chk("async_err", {3'b000, bus_if.err}, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        bus_if.code = SEL_I2;
        @(negedge clk);
        chk("final_o", bus_if.O, 4'h2);
        chk("final_err", {3'b000, bus_if.err}, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
